// File: rtl/udp_cmd_pkg.sv
// Shared definitions for the UDP command receiver.
//   state_t      : parser states
//   W_*          : header word indices in the 16-bit-shifted MAC word stream
//   calc_pairs() : number of (addr, data) pairs announced by the UDP length
`timescale 1ns/1ps
package udp_cmd_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_ADDR,
        S_DATA,
        S_TAIL,
        S_DISCARD
    } state_t;

    localparam logic [3:0] W_DST_HI   = 4'd0;   // pad16 + dst[0:1]
    localparam logic [3:0] W_DST_LO   = 4'd1;   // dst[2:5]
    localparam logic [3:0] W_ETH      = 4'd3;   // src[4:5] + ethertype
    localparam logic [3:0] W_IP_VER   = 4'd4;   // ver/IHL, TOS, total length
    localparam logic [3:0] W_IP_PROTO = 4'd6;   // TTL, protocol, checksum
    localparam logic [3:0] W_IP_DST   = 4'd8;
    localparam logic [3:0] W_UDP_PORT = 4'd9;   // sport, dport
    localparam logic [3:0] W_UDP_LEN  = 4'd10;  // udp length, checksum
    localparam logic [3:0] W_MAGIC    = 4'd11;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_VER_IHL     = 8'h45;
    localparam logic [7:0]  PROTO_UDP      = 8'd17;
    // UDP header (8) plus magic word (4) precede the first pair.
    localparam logic [15:0] UDP_MIN_LEN    = 16'd12;

    // Whole 8-byte pairs after the magic, clamped; a partial pair is ignored.
    function automatic logic [6:0] calc_pairs(input logic [15:0] udp_len,
                                              input logic [6:0]  max_pairs);
        logic [15:0] n;
        n = (udp_len - UDP_MIN_LEN) >> 3;
        return (n > {9'd0, max_pairs}) ? max_pairs : n[6:0];
    endfunction

endpackage

// File: rtl/udp_hdr_check.sv
// Combinational per-word header match.
//   idx         : header word index of the current word (0..11)
//   data        : current frame word
//   hi_local    : word 0 matched the upper 16 bits of the local MAC
//   hi_bcast    : word 0 matched the upper 16 bits of broadcast
//   ok          : current word satisfies its header rule (1 for unchecked words)
//   is_local_hi : this word's low half matches the local MAC upper bytes
//   is_bcast_hi : this word's low half is FFFF
`timescale 1ns/1ps
module udp_hdr_check
    import udp_cmd_pkg::*;
#(
    parameter logic [47:0] MAC_ADDR  = 48'h0001_0203_0405,
    parameter logic [31:0] IP_ADDR   = 32'hC0A8_0A0A,
    parameter logic [15:0] UDP_PORT  = 16'd50000,
    parameter logic [31:0] CMD_MAGIC = 32'h434D_4431
) (
    input  logic [3:0]  idx,
    input  logic [31:0] data,
    input  logic        hi_local,
    input  logic        hi_bcast,
    output logic        ok,
    output logic        is_local_hi,
    output logic        is_bcast_hi
);

    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned (which would infer a latch).
    always_comb begin
        is_local_hi = (data[15:0] == MAC_ADDR[47:32]);
        is_bcast_hi = (data[15:0] == 16'hFFFF);
        ok          = 1'b1;
        case (idx)
            W_DST_HI:   ok = is_local_hi | is_bcast_hi;
            // The MAC spans two words: the lower four bytes must belong to the
            // same address (local or broadcast) as the upper two.
            W_DST_LO:   ok = (hi_local && (data == MAC_ADDR[31:0])) ||
                             (hi_bcast && (data == 32'hFFFF_FFFF));
            W_ETH:      ok = (data[15:0] == ETHERTYPE_IPV4);
            W_IP_VER:   ok = (data[31:24] == IP_VER_IHL);
            W_IP_PROTO: ok = (data[23:16] == PROTO_UDP);
            W_IP_DST:   ok = (data == IP_ADDR);
            W_UDP_PORT: ok = (data[15:0] == UDP_PORT);
            W_UDP_LEN:  ok = (data[31:16] >= UDP_MIN_LEN);
            W_MAGIC:    ok = (data == CMD_MAGIC);
            default:    ok = 1'b1;
        endcase
    end

endmodule

// File: rtl/udp_cmd_rx.sv
// UDP command extractor on the MAC RX FIFO word stream.
//   clk, rst_n                     : sysclk, async active-low reset
//   i_rx_data/vld/sop/eop/err      : RX word stream (first byte in [31:24])
//   o_rx_rdy                       : word accepted when i_rx_vld & o_rx_rdy
//   o_def_addr/o_def_data/o_def_wren, i_def_rdy : command handshake
//   o_pkt_cnt / o_drop_cnt         : accepted / dropped frame counters
`timescale 1ns/1ps
module udp_cmd_rx
    import udp_cmd_pkg::*;
#(
    parameter logic [47:0] MAC_ADDR  = 48'h0001_0203_0405,
    parameter logic [31:0] IP_ADDR   = 32'hC0A8_0A0A,
    parameter logic [15:0] UDP_PORT  = 16'd50000,
    parameter logic [31:0] CMD_MAGIC = 32'h434D_4431,
    parameter int          MAX_PAIRS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_rx_data,
    input  logic        i_rx_vld,
    input  logic        i_rx_sop,
    input  logic        i_rx_eop,
    input  logic        i_rx_err,
    output logic        o_rx_rdy,
    output logic [31:0] o_def_addr,
    output logic [31:0] o_def_data,
    output logic        o_def_wren,
    input  logic        i_def_rdy,
    output logic [15:0] o_pkt_cnt,
    output logic [15:0] o_drop_cnt
);

    localparam logic [6:0] MAX_PAIRS_W = 7'(MAX_PAIRS);

    state_t      state, state_nx;
    logic [3:0]  idx, idx_nx;
    logic [6:0]  pair_cnt, pair_cnt_nx;
    logic [6:0]  pair_total, pair_total_nx;
    logic [31:0] addr_q, addr_nx;
    logic        hi_local, hi_local_nx;
    logic        hi_bcast, hi_bcast_nx;
    logic        rdy_q;
    logic        beat, load_cmd, pkt_inc;
    logic [1:0]  drop_inc;
    logic        hdr_ok, is_local_hi, is_bcast_hi;

    // A sop word is always header word 0, whatever the current index says.
    udp_hdr_check #(
        .MAC_ADDR (MAC_ADDR),
        .IP_ADDR  (IP_ADDR),
        .UDP_PORT (UDP_PORT),
        .CMD_MAGIC(CMD_MAGIC)
    ) u_hdr_check (
        .idx        (i_rx_sop ? W_DST_HI : idx),
        .data       (i_rx_data),
        .hi_local   (hi_local),
        .hi_bcast   (hi_bcast),
        .ok         (hdr_ok),
        .is_local_hi(is_local_hi),
        .is_bcast_hi(is_bcast_hi)
    );

    // Only a DATA word needs the output register; stall it while a command
    // is still waiting for i_def_rdy.
    assign o_rx_rdy = rdy_q & ~((state == S_DATA) & o_def_wren & ~i_def_rdy);
    assign beat     = i_rx_vld & o_rx_rdy;

    always_comb begin
        state_nx      = state;
        idx_nx        = idx;
        pair_cnt_nx   = pair_cnt;
        pair_total_nx = pair_total;
        addr_nx       = addr_q;
        hi_local_nx   = hi_local;
        hi_bcast_nx   = hi_bcast;
        load_cmd      = 1'b0;
        pkt_inc       = 1'b0;
        drop_inc      = 2'd0;

        if (beat && i_rx_sop) begin
            // A new frame aborts whatever was in progress.
            if (state != S_IDLE) drop_inc = 2'd1;
            hi_local_nx = is_local_hi;
            hi_bcast_nx = is_bcast_hi;
            idx_nx      = 4'd1;
            pair_cnt_nx = 7'd0;
            if (i_rx_eop) begin
                drop_inc = drop_inc + 2'd1;
                state_nx = S_IDLE;
            end else begin
                state_nx = hdr_ok ? S_HDR : S_DISCARD;
            end
        end else if (beat) begin
            case (state)
                S_IDLE: ;  // stray words outside a frame are swallowed
                S_HDR: begin
                    idx_nx = idx + 4'd1;
                    if (idx == W_UDP_LEN)
                        pair_total_nx = calc_pairs(i_rx_data[31:16], MAX_PAIRS_W);
                    if (i_rx_eop) begin
                        state_nx = S_IDLE;
                        if (hdr_ok && (idx == W_MAGIC) && !i_rx_err) pkt_inc  = 1'b1;
                        else                                         drop_inc = 2'd1;
                    end else if (!hdr_ok) begin
                        state_nx = S_DISCARD;
                    end else if (idx == W_MAGIC) begin
                        state_nx = (pair_total == 7'd0) ? S_TAIL : S_ADDR;
                    end
                end
                S_ADDR: begin
                    addr_nx = i_rx_data;
                    if (i_rx_eop) state_nx = S_IDLE;
                    else          state_nx = S_DATA;
                end
                S_DATA: begin
                    load_cmd    = 1'b1;
                    pair_cnt_nx = pair_cnt + 7'd1;
                    if (i_rx_eop)                              state_nx = S_IDLE;
                    else if ((pair_cnt + 7'd1) == pair_total)  state_nx = S_TAIL;
                    else                                       state_nx = S_ADDR;
                end
                S_TAIL:    if (i_rx_eop) state_nx = S_IDLE;
                S_DISCARD: if (i_rx_eop) begin
                    state_nx = S_IDLE;
                    drop_inc = 2'd1;
                end
                default:   state_nx = S_IDLE;
            endcase
            // Past the header every check has passed: only the MAC error decides.
            if (i_rx_eop && ((state == S_ADDR) || (state == S_DATA) || (state == S_TAIL))) begin
                if (i_rx_err) drop_inc = 2'd1;
                else          pkt_inc  = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            idx        <= 4'd0;
            pair_cnt   <= 7'd0;
            pair_total <= 7'd0;
            addr_q     <= 32'd0;
            hi_local   <= 1'b0;
            hi_bcast   <= 1'b0;
            rdy_q      <= 1'b0;
            o_pkt_cnt  <= 16'd0;
            o_drop_cnt <= 16'd0;
        end else begin
            state      <= state_nx;
            idx        <= idx_nx;
            pair_cnt   <= pair_cnt_nx;
            pair_total <= pair_total_nx;
            addr_q     <= addr_nx;
            hi_local   <= hi_local_nx;
            hi_bcast   <= hi_bcast_nx;
            rdy_q      <= 1'b1;
            o_pkt_cnt  <= o_pkt_cnt + {15'd0, pkt_inc};
            o_drop_cnt <= o_drop_cnt + {14'd0, drop_inc};
        end
    end

    // Output register: a load can only happen when it is empty or being
    // accepted this cycle, because o_rx_rdy holds DATA words back otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_def_wren <= 1'b0;
            o_def_addr <= 32'd0;
            o_def_data <= 32'd0;
        end else if (load_cmd) begin
            o_def_wren <= 1'b1;
            o_def_addr <= addr_q;
            o_def_data <= i_rx_data;
        end else if (o_def_wren && i_def_rdy) begin
            o_def_wren <= 1'b0;
            o_def_addr <= 32'd0;
            o_def_data <= 32'd0;
        end
    end

endmodule

// File: tb/tb_udp_cmd_rx.sv
// Self-checking bench for udp_cmd_rx: directed frames built byte by byte,
// a byte-level reference model filling a command scoreboard and frame
// counters, and one compare process watching the command handshake.
`timescale 1ns/1ps
module tb_udp_cmd_rx;

    localparam logic [47:0] MAC   = 48'h0001_0203_0405;
    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
    localparam logic [31:0] IP    = 32'hC0A8_0A0A;
    localparam logic [15:0] PORT  = 16'd50000;
    localparam logic [31:0] MAGIC = 32'h434D_4431;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] i_rx_data = '0;
    logic        i_rx_vld = 1'b0, i_rx_sop = 1'b0, i_rx_eop = 1'b0, i_rx_err = 1'b0;
    logic        o_rx_rdy;
    logic [31:0] o_def_addr, o_def_data;
    logic        o_def_wren;
    logic        i_def_rdy = 1'b1;
    logic [15:0] o_pkt_cnt, o_drop_cnt;

    udp_cmd_rx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_rx_data (i_rx_data),
        .i_rx_vld  (i_rx_vld),
        .i_rx_sop  (i_rx_sop),
        .i_rx_eop  (i_rx_eop),
        .i_rx_err  (i_rx_err),
        .o_rx_rdy  (o_rx_rdy),
        .o_def_addr(o_def_addr),
        .o_def_data(o_def_data),
        .o_def_wren(o_def_wren),
        .i_def_rdy (i_def_rdy),
        .o_pkt_cnt (o_pkt_cnt),
        .o_drop_cnt(o_drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } cmd_t;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] frm[$];
    logic [31:0] pay[$];
    cmd_t        exp_q[$];
    int          exp_pkt  = 0;
    int          exp_drop = 0;
    int          rdy_low_cnt = 0;
    int          stall_left = 0;
    bit          stall_arm = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame image: 2 pad bytes, Ethernet, IPv4, UDP, magic, then pay[] and padding.
    task automatic build(input logic [47:0] dmac, input logic [15:0] dport,
                         input logic [15:0] ulen, input int pad_words);
        logic [7:0]  b[$];
        logic [15:0] totlen;
        totlen = ulen + 16'd20;
        b = {8'h00, 8'h00};
        for (int i = 0; i < 6; i++) b.push_back(dmac[47-8*i -: 8]);
        b = {b, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h08, 8'h00};
        b = {b, 8'h45, 8'h00, totlen[15:8], totlen[7:0], 8'h00, 8'h01, 8'h00, 8'h00};
        b = {b, 8'h40, 8'h11, 8'h00, 8'h00, 8'hC0, 8'hA8, 8'h0A, 8'h01};
        b = {b, IP[31:24], IP[23:16], IP[15:8], IP[7:0], 8'h12, 8'h34, dport[15:8], dport[7:0]};
        b = {b, ulen[15:8], ulen[7:0], 8'h00, 8'h00, MAGIC[31:24], MAGIC[23:16], MAGIC[15:8], MAGIC[7:0]};
        frm = {};
        for (int i = 0; i < b.size(); i += 4) frm.push_back({b[i], b[i+1], b[i+2], b[i+3]});
        foreach (pay[i]) frm.push_back(pay[i]);
        for (int i = 0; i < pad_words; i++) frm.push_back(32'd0);
    endtask

    // Reference: decode the first nwords of frm as bytes and apply the
    // acceptance rules; queue the commands the frame must produce.
    task automatic model(input int nwords, input bit has_eop, input bit err);
        logic [7:0]  b[$];
        logic [47:0] dst;
        int          ulen, npairs;
        bit          ok;
        for (int i = 0; i < nwords; i++)
            b = {b, frm[i][31:24], frm[i][23:16], frm[i][15:8], frm[i][7:0]};
        b = b[2:$];
        ok = (nwords >= 12);
        if (ok) begin
            dst  = {b[0], b[1], b[2], b[3], b[4], b[5]};
            ulen = {b[38], b[39]};
            ok = (dst == MAC || dst == BCAST) && ({b[12], b[13]} == 16'h0800) &&
                 (b[14] == 8'h45) && (b[23] == 8'd17) &&
                 ({b[30], b[31], b[32], b[33]} == IP) && ({b[36], b[37]} == PORT) &&
                 (ulen >= 12) && ({b[42], b[43], b[44], b[45]} == MAGIC);
            if (ok) begin
                npairs = (ulen - 12) / 8;
                if (npairs > 64) npairs = 64;
                for (int i = 0; i < npairs; i++)
                    if (13 + 2*i < nwords) exp_q.push_back('{a: frm[12+2*i], d: frm[13+2*i]});
            end
        end
        if (has_eop && ok && !err) exp_pkt++;
        else                       exp_drop++;
    endtask

    // Drive frm[first..last]; sop only on word 0, eop/err on the last word if asked.
    task automatic send(input int first, input int last, input bit eop, input bit err);
        int t;
        for (int i = first; i <= last; i++) begin
            @(negedge clk);
            i_rx_vld  = 1'b1;
            i_rx_sop  = (i == 0);
            i_rx_eop  = eop && (i == last);
            i_rx_err  = eop && err && (i == last);
            i_rx_data = frm[i];
            t = 0;
            #1;
            while (!o_rx_rdy && t < 200) begin
                @(negedge clk);
                #1;
                t++;
            end
            if (t >= 200) begin
                n_total++;
                n_bad++;
                $display("FAIL rx_rdy_timeout: word %0d never accepted", i);
            end
            @(posedge clk);
        end
        @(negedge clk);
        i_rx_vld = 1'b0; i_rx_sop = 1'b0; i_rx_eop = 1'b0; i_rx_err = 1'b0;
    endtask

    task automatic finish_frame(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        #1;
        check({name, "_cmds_left"}, exp_q.size(), 0);
        check({name, "_pkt_cnt"},  o_pkt_cnt,  exp_pkt);
        check({name, "_drop_cnt"}, o_drop_cnt, exp_drop);
    endtask

    // Command sink: optionally stalls 10 cycles on the first command after arming.
    initial begin
        forever begin
            @(negedge clk);
            if (stall_arm && o_def_wren) begin
                stall_arm  = 1'b0;
                stall_left = 10;
            end
            if (stall_left > 0) begin
                i_def_rdy = 1'b0;
                stall_left--;
            end else begin
                i_def_rdy = 1'b1;
            end
        end
    end

    // Compare process: every accepted command against the scoreboard, and
    // held commands must stay unchanged until accepted.
    bit          hold = 1'b0;
    logic [31:0] hold_a, hold_d;
    initial begin
        cmd_t c;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                hold = 1'b0;
                continue;
            end
            if (!o_rx_rdy) rdy_low_cnt++;
            if (hold) begin
                check("held_wren", {31'd0, o_def_wren}, 32'd1);
                check("held_addr", o_def_addr, hold_a);
                check("held_data", o_def_data, hold_d);
            end
            if (o_def_wren && i_def_rdy) begin
                hold = 1'b0;
                if (exp_q.size() == 0) begin
                    n_total++;
                    n_bad++;
                    $display("FAIL unexpected_cmd: got addr %0h data %0h expected none", o_def_addr, o_def_data);
                end else begin
                    c = exp_q.pop_front();
                    check("cmd_addr", o_def_addr, c.a);
                    check("cmd_data", o_def_data, c.d);
                end
            end else if (o_def_wren) begin
                hold   = 1'b1;
                hold_a = o_def_addr;
                hold_d = o_def_data;
            end else begin
                hold = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values.
        repeat (3) @(negedge clk);
        #1;
        check("rst_rx_rdy", {31'd0, o_rx_rdy}, 32'd0);
        check("rst_wren",   {31'd0, o_def_wren}, 32'd0);
        check("rst_addr",   o_def_addr, 32'd0);
        check("rst_data",   o_def_data, 32'd0);
        check("rst_pkt",    o_pkt_cnt, 32'd0);
        check("rst_drop",   o_drop_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("rdy_after_rst", {31'd0, o_rx_rdy}, 32'd1);

        // Valid frame, two pairs.
        pay = {32'h10, 32'hAA, 32'h14, 32'hBB};
        build(MAC, PORT, 16'd28, 0);
        model(frm.size(), 1'b1, 1'b0);
        check("pin_t1_ncmd", exp_q.size(), 2);
        check("pin_t1_a0", exp_q[0].a, 32'h10);
        check("pin_t1_d0", exp_q[0].d, 32'hAA);
        check("pin_t1_a1", exp_q[1].a, 32'h14);
        check("pin_t1_d1", exp_q[1].d, 32'hBB);
        send(0, frm.size() - 1, 1'b1, 1'b0);
        finish_frame("t1");
        check("pin_t1_pkt", o_pkt_cnt, 32'd1);

        // Wrong UDP port: dropped, never back-pressured.
        rdy_low_cnt = 0;
        build(MAC, 16'd50001, 16'd28, 0);
        model(frm.size(), 1'b1, 1'b0);
        send(0, frm.size() - 1, 1'b1, 1'b0);
        finish_frame("t2");
        check("t2_rdy_low_cycles", rdy_low_cnt, 0);
        check("pin_t2_drop", o_drop_cnt, 32'd1);

        // Sink stalls 10 cycles on the first command.
        rdy_low_cnt = 0;
        stall_arm   = 1'b1;
        build(MAC, PORT, 16'd28, 0);
        model(frm.size(), 1'b1, 1'b0);
        send(0, frm.size() - 1, 1'b1, 1'b0);
        finish_frame("t3");
        check("t3_rdy_went_low", {31'd0, rdy_low_cnt > 0}, 32'd1);

        // Minimum-size frame: one pair plus two padding words.
        pay = {32'h20, 32'hCC};
        build(MAC, PORT, 16'd20, 2);
        model(frm.size(), 1'b1, 1'b0);
        check("pin_t4_ncmd", exp_q.size(), 1);
        send(0, frm.size() - 1, 1'b1, 1'b0);
        finish_frame("t4");

        // Early eop at w6, then a frame cut at w6 by the next sop.
        pay = {32'h30, 32'hDD};
        build(MAC, PORT, 16'd20, 0);
        model(7, 1'b1, 1'b0);
        send(0, 6, 1'b1, 1'b0);
        finish_frame("t5a");
        model(7, 1'b0, 1'b0);
        send(0, 6, 1'b0, 1'b0);
        model(frm.size(), 1'b1, 1'b0);
        send(0, frm.size() - 1, 1'b1, 1'b0);
        finish_frame("t5b");

        // Broadcast MAC with MAC error: command still emitted, frame dropped.
        pay = {32'h40, 32'hEE};
        build(BCAST, PORT, 16'd20, 0);
        model(frm.size(), 1'b1, 1'b1);
        check("pin_t6_ncmd", exp_q.size(), 1);
        send(0, frm.size() - 1, 1'b1, 1'b1);
        finish_frame("t6");

        // udp_len below the minimum.
        build(MAC, PORT, 16'd11, 0);
        model(frm.size(), 1'b1, 1'b0);
        send(0, frm.size() - 1, 1'b1, 1'b0);
        finish_frame("t7");

        // 70 pairs announced and present: clamped to 64, the rest drained.
        pay = {};
        for (int i = 0; i < 70; i++) begin
            pay.push_back(32'h100 + 32'(4 * i));
            pay.push_back(32'hD000_0000 + 32'(i));
        end
        build(MAC, PORT, 16'(12 + 8 * 70), 0);
        model(frm.size(), 1'b1, 1'b0);
        check("pin_t8_ncmd", exp_q.size(), 64);
        check("pin_t8_last_a", exp_q[63].a, 32'h1FC);
        send(0, frm.size() - 1, 1'b1, 1'b0);
        finish_frame("t8");

        // Reset after w8; the remainder arrives without sop and is ignored.
        pay = {32'h50, 32'h11, 32'h54, 32'h22};
        build(MAC, PORT, 16'd28, 0);
        send(0, 8, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rst2_rx_rdy", {31'd0, o_rx_rdy}, 32'd0);
        check("rst2_wren",   {31'd0, o_def_wren}, 32'd0);
        check("rst2_pkt",    o_pkt_cnt, 32'd0);
        check("rst2_drop",   o_drop_cnt, 32'd0);
        exp_pkt  = 0;
        exp_drop = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send(9, frm.size() - 1, 1'b1, 1'b0);
        finish_frame("t9a");
        model(frm.size(), 1'b1, 1'b0);
        send(0, frm.size() - 1, 1'b1, 1'b0);
        finish_frame("t9b");
        check("pin_t9_pkt", o_pkt_cnt, 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
